audio_voice_scheduler: RTL

- Time-multiplexes one synchronous single-port sample ROM across NUM_VOICES playback voices (e.g. background loop, click) at a fixed sample rate derived from CLOCK_50.
- Per sample tick: sequences ROM reads for each voice, advances per-voice address pointers (wrap/loop/stop), sums samples with saturation, emits one mixed sample with a valid pulse.
- Sits between the sample ROMs and the audio codec output path, replacing ad-hoc per-voice address counters and priority muxing.

---
 rtl/audio_pkg.sv | 40 ++++
 rtl/audio_tick_gen.sv | 37 +++
 rtl/audio_voice_scheduler.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types, constants and saturation helper for the audio blocks
//
// Purpose : scan FSM state encoding, default sample-tick divider, sample width
//           and a signed saturation function used when narrowing a mix.
// Ports   : none (package).

package audio_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_ACCUM,
      ST_OUTPUT
   } scan_state_e;

   // 50 MHz / 16667 ~= 3000 samples per second
   localparam int TICK_DIV_DEFAULT = 16667;
   localparam int SAMPLE_W         = 16;

   // Working width for saturate(); callers sign-extend into it and truncate out.
   localparam int SAT_W = 32;

   // Clamp val to the signed range of a width-bit integer.
   function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] val,
                                                        input int width);
      logic signed [SAT_W-1:0] max_v;
      logic signed [SAT_W-1:0] min_v;
      logic signed [SAT_W-1:0] res;
      max_v = $signed((SAT_W'(1) << (width - 1)) - SAT_W'(1));
      min_v = ~max_v;
      res   = val;
      if (val > max_v) begin
         res = max_v;
      end else if (val < min_v) begin
         res = min_v;
      end
      return res;
   endfunction

endpackage

// File: rtl/audio_tick_gen.sv
// rtl/audio_tick_gen.sv - free-running divider producing a single-cycle tick
//
// Purpose : counts 0..DIV-1 and asserts tick_o while the count is DIV-1.
// Ports   : clk_i  - clock
//           rst_ni - asynchronous active-low reset (count returns to 0)
//           tick_o - one-cycle pulse every DIV cycles

module audio_tick_gen
   import audio_pkg::*;
#(
   parameter int DIV = TICK_DIV_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic tick_o
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      tick_o = (cnt_q == CNT_LAST);
      cnt_d  = tick_o ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/audio_voice_scheduler.sv
// rtl/audio_voice_scheduler.sv - shares one sample ROM across voices and mixes them per tick
//
// Purpose : on every sample tick, reads one sample per voice from a synchronous
//           ROM (voice 0 first), advances each voice pointer (wrap/loop/stop),
//           sums active voices and emits a saturated mix with a valid pulse.
// Ports   : CLOCK_50     - clock
//           resetn       - asynchronous active-low reset
//           voice_start  - per-voice first address, voice i at [i*ADDR_W +: ADDR_W]
//           voice_end    - per-voice last address (inclusive)
//           voice_loop   - 1 = wrap to start after end, 0 = one-shot
//           trigger/stop - single-cycle pulses, applied at the next scan start
//           rom_addr     - ROM address; rom_q is the data one cycle later
//           mix_out      - signed saturated mix, held between updates
//           mix_valid    - one-cycle pulse when mix_out updates
//           voice_active - per-voice playing flag
//           overrun      - sticky, a tick arrived while a scan was running
// Options : VOICE_GAIN_EN adds voice_shift (3 bits per voice), an arithmetic
//           right shift applied to each voice sample before it is summed.

module audio_voice_scheduler
   import audio_pkg::*;
#(
   parameter int NUM_VOICES = 2,
   parameter int ADDR_W     = 15,
   parameter int DATA_W     = SAMPLE_W,
   parameter int TICK_DIV   = TICK_DIV_DEFAULT
) (
   input  logic                           CLOCK_50,
   input  logic                           resetn,
   input  logic [NUM_VOICES*ADDR_W-1:0]   voice_start,
   input  logic [NUM_VOICES*ADDR_W-1:0]   voice_end,
   input  logic [NUM_VOICES-1:0]          voice_loop,
   input  logic [NUM_VOICES-1:0]          trigger,
   input  logic [NUM_VOICES-1:0]          stop,
   output logic [ADDR_W-1:0]              rom_addr,
   input  logic signed [DATA_W-1:0]       rom_q,
   output logic signed [DATA_W-1:0]       mix_out,
   output logic                           mix_valid,
   output logic [NUM_VOICES-1:0]          voice_active,
   output logic                           overrun
`ifdef VOICE_GAIN_EN
   ,
   input  logic [NUM_VOICES*3-1:0]        voice_shift
`endif
);

   localparam int ACC_W  = DATA_W + $clog2(NUM_VOICES) + 1;
   localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam logic [VIDX_W-1:0] LAST_V = VIDX_W'(NUM_VOICES - 1);

   scan_state_e             state_q, state_d;
   logic [VIDX_W-1:0]       vidx_q, vidx_d;
   logic [ADDR_W-1:0]       ptr_q [NUM_VOICES];
   logic [ADDR_W-1:0]       ptr_d [NUM_VOICES];
   logic [NUM_VOICES-1:0]   active_q, active_d;
   logic [NUM_VOICES-1:0]   pend_trig_q, pend_trig_d;
   logic [NUM_VOICES-1:0]   pend_stop_q, pend_stop_d;
   logic [ADDR_W-1:0]       rom_addr_q, rom_addr_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [DATA_W-1:0] mix_q, mix_d;
   logic                    mix_valid_q, mix_valid_d;
   logic                    overrun_q, overrun_d;

   logic                    tick;
   logic [NUM_VOICES-1:0]   trig_now;
   logic [NUM_VOICES-1:0]   stop_now;
   logic [ADDR_W-1:0]       start_a [NUM_VOICES];
   logic [ADDR_W-1:0]       end_a   [NUM_VOICES];
   logic signed [ACC_W-1:0] sample_ext;
   logic signed [ACC_W-1:0] sample_gain;

   audio_tick_gen #(.DIV(TICK_DIV)) u_tick (
      .clk_i  (CLOCK_50),
      .rst_ni (resetn),
      .tick_o (tick)
   );

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_unpack
      assign start_a[g] = voice_start[g*ADDR_W +: ADDR_W];
      assign end_a[g]   = voice_end[g*ADDR_W +: ADDR_W];
   end

   // A pulse arriving on the very cycle the scan starts is honoured immediately.
   assign trig_now   = pend_trig_q | trigger;
   assign stop_now   = pend_stop_q | stop;
   assign sample_ext = {{(ACC_W-DATA_W){rom_q[DATA_W-1]}}, rom_q};

`ifdef VOICE_GAIN_EN
   logic [2:0] shift_a [NUM_VOICES];
   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_shift
      assign shift_a[g] = voice_shift[g*3 +: 3];
   end
   assign sample_gain = sample_ext >>> shift_a[vidx_q];
`else
   assign sample_gain = sample_ext;
`endif

   always_comb begin
      state_d     = state_q;
      vidx_d      = vidx_q;
      ptr_d       = ptr_q;
      active_d    = active_q;
      pend_trig_d = trig_now;
      pend_stop_d = stop_now;
      rom_addr_d  = rom_addr_q;
      acc_d       = acc_q;
      mix_d       = mix_q;
      mix_valid_d = 1'b0;
      overrun_d   = overrun_q | (tick && (state_q != ST_IDLE));

      case (state_q)
         ST_IDLE: begin
            if (tick) begin
               for (int i = 0; i < NUM_VOICES; i++) begin
                  if (trig_now[i]) begin
                     ptr_d[i]    = start_a[i];
                     active_d[i] = 1'b1;
                  end else if (stop_now[i]) begin
                     active_d[i] = 1'b0;
                  end
               end
               pend_trig_d = '0;
               pend_stop_d = '0;
               acc_d       = '0;
               vidx_d      = '0;
               rom_addr_d  = ptr_d[0];
               state_d     = ST_FETCH;
            end
         end
         ST_FETCH: state_d = ST_ACCUM;
         ST_ACCUM: begin
            // Inactive voices still spend their slot so the output timing never moves.
            if (active_q[vidx_q]) begin
               acc_d = acc_q + sample_gain;
               if (ptr_q[vidx_q] == end_a[vidx_q]) begin
                  if (voice_loop[vidx_q]) begin
                     ptr_d[vidx_q] = start_a[vidx_q];
                  end else begin
                     active_d[vidx_q] = 1'b0;
                  end
               end else begin
                  ptr_d[vidx_q] = ptr_q[vidx_q] + ADDR_W'(1);
               end
            end
            if (vidx_q == LAST_V) begin
               // Registered here so mix_out and mix_valid appear together in OUTPUT.
               mix_d       = DATA_W'(saturate(SAT_W'(acc_d), DATA_W));
               mix_valid_d = 1'b1;
               state_d     = ST_OUTPUT;
            end else begin
               vidx_d     = vidx_q + VIDX_W'(1);
               rom_addr_d = ptr_q[vidx_d];
               state_d    = ST_FETCH;
            end
         end
         ST_OUTPUT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         vidx_q      <= '0;
         ptr_q       <= '{default: '0};
         active_q    <= '0;
         pend_trig_q <= '0;
         pend_stop_q <= '0;
         rom_addr_q  <= '0;
         acc_q       <= '0;
         mix_q       <= '0;
         mix_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         vidx_q      <= vidx_d;
         ptr_q       <= ptr_d;
         active_q    <= active_d;
         pend_trig_q <= pend_trig_d;
         pend_stop_q <= pend_stop_d;
         rom_addr_q  <= rom_addr_d;
         acc_q       <= acc_d;
         mix_q       <= mix_d;
         mix_valid_q <= mix_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rom_addr     = rom_addr_q;
   assign mix_out      = mix_q;
   assign mix_valid    = mix_valid_q;
   assign voice_active = active_q;
   assign overrun      = overrun_q;

endmodule
